// File: rtl/mc_control_pkg.sv
// Shared definitions for the multicycle RV32I main control: state encodings,
// control-field codes, opcodes, fault codes and the decoded control word.
package mc_control_pkg;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        EXEC_R  = 4'd3,
        WB_R    = 4'd4,
        ADDR    = 4'd5,
        MEM_RD  = 4'd6,
        MEM_WR  = 4'd7,
        WB_LD   = 4'd8,
        BRANCH  = 4'd9,
        FAULT   = 4'd15
    } state_t;

    // aluop codes must match the downstream ALU-control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic       pcsource;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    // States that hold on mem_ready and run the wait counter
    function automatic logic is_wait_state(state_t s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control-to-datapath bundle: instruction/memory status in, datapath enables out.
interface mc_control_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       pcsource;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] fault;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regwrite, alusrca, pcsource, alusrcb, aluop,
               fault, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regwrite, alusrca, pcsource, alusrcb, aluop,
               fault, state
    );
endinterface

// File: rtl/mc_control_outdec.sv
// Combinational state -> control-word decoder. Moore, except the FETCH
// instruction-register and PC writes, which are qualified by mem_ready.
module mc_outdec
    import mc_control_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memread  = 1'b1;
                ctrl.alusrcb  = SRCB_FOUR;
                ctrl.aluop    = ALUOP_ADD;
                ctrl.irwrite  = mem_ready;
                ctrl.pcwrite  = mem_ready;
            end
            // ALU is idle here, so it precomputes the branch target
            DECODE: begin
                ctrl.alusrcb  = SRCB_BOFF;
                ctrl.aluop    = ALUOP_ADD;
            end
            EXEC_R: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_REG;
                ctrl.aluop    = ALUOP_FUNCT;
            end
            WB_R: begin
                ctrl.regwrite = 1'b1;
            end
            ADDR: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_IMM;
                ctrl.aluop    = ALUOP_ADD;
            end
            MEM_RD: begin
                ctrl.memread  = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEM_WR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            WB_LD: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = SRCB_REG;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle main control FSM for RV32I (R-type, lw, sw, beq) with memory
// wait handshake, wait timeout and a sticky fault state.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    mc_control_if.master  bus
);

    localparam logic [7:0] LIMIT = MEM_TIMEOUT[7:0];

    state_t     cur;
    logic [7:0] wait_cnt;
    logic [1:0] fault_q;
    ctrl_t      ctrl;
    logic       timeout_hit;

    // mem_ready on the limit cycle wins over the timeout
    assign timeout_hit = (LIMIT != 8'd0) && (wait_cnt == LIMIT) && !bus.mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= S_RESET;
            wait_cnt <= 8'd0;
            fault_q  <= FAULT_NONE;
        end else begin
            // Counter runs only while a wait state is held; zero everywhere else,
            // so it is already clear on entry to each wait state.
            if (is_wait_state(cur) && !bus.mem_ready && !timeout_hit)
                wait_cnt <= (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
            else
                wait_cnt <= 8'd0;

            case (cur)
                S_RESET: cur <= FETCH;
                FETCH: begin
                    if (bus.mem_ready) begin
                        cur <= DECODE;
                    end else if (timeout_hit) begin
                        cur     <= FAULT;
                        fault_q <= FAULT_TIMEOUT;
                    end
                end
                DECODE: begin
                    case (bus.opcode)
                        OP_RTYPE:           cur <= EXEC_R;
                        OP_LOAD, OP_STORE:  cur <= ADDR;
                        OP_BRANCH:          cur <= BRANCH;
                        default: begin
                            cur     <= FAULT;
                            fault_q <= FAULT_ILLEGAL;
                        end
                    endcase
                end
                EXEC_R:  cur <= WB_R;
                WB_R:    cur <= FETCH;
                ADDR:    cur <= (bus.opcode == OP_LOAD) ? MEM_RD : MEM_WR;
                MEM_RD: begin
                    if (bus.mem_ready) begin
                        cur <= WB_LD;
                    end else if (timeout_hit) begin
                        cur     <= FAULT;
                        fault_q <= FAULT_TIMEOUT;
                    end
                end
                MEM_WR: begin
                    if (bus.mem_ready) begin
                        cur <= FETCH;
                    end else if (timeout_hit) begin
                        cur     <= FAULT;
                        fault_q <= FAULT_TIMEOUT;
                    end
                end
                WB_LD:   cur <= FETCH;
                BRANCH:  cur <= FETCH;
                FAULT:   cur <= FAULT;
                default: cur <= S_RESET;
            endcase
        end
    end

    mc_outdec u_outdec (
        .state     (cur),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.pcwrite     = ctrl.pcwrite;
    assign bus.pcwritecond = ctrl.pcwritecond;
    assign bus.iord        = ctrl.iord;
    assign bus.memread     = ctrl.memread;
    assign bus.memwrite    = ctrl.memwrite;
    assign bus.irwrite     = ctrl.irwrite;
    assign bus.memtoreg    = ctrl.memtoreg;
    assign bus.regwrite    = ctrl.regwrite;
    assign bus.alusrca     = ctrl.alusrca;
    assign bus.pcsource    = ctrl.pcsource;
    assign bus.alusrcb     = ctrl.alusrcb;
    assign bus.aluop       = ctrl.aluop;
    assign bus.fault       = fault_q;
    assign bus.state       = cur;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

    localparam int T = 4;

    localparam bit [6:0] R_OP  = 7'b0110011;
    localparam bit [6:0] LW_OP = 7'b0000011;
    localparam bit [6:0] SW_OP = 7'b0100011;
    localparam bit [6:0] BQ_OP = 7'b1100011;

    typedef struct {
        bit       rst;
        bit [6:0] op;
        bit       mr;
    } in_t;

    typedef struct {
        int        st;
        bit [13:0] ctl;
        bit [1:0]  flt;
        string     tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    in_t  in_q[$];
    exp_t exp_q[$];
    bit [1:0] m_flt;
    bit   plan_ready = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   n_plan = 0;

    mc_control_if bus ();

    mc_control #(.MEM_TIMEOUT(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic bit [13:0] ctl_of(int st, bit mr);
        bit pw = 0, pwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        bit m2r = 0, rw = 0, asa = 0, psrc = 0;
        bit [1:0] srcb = 2'b00, aop = 2'b00;
        case (st)
            1: begin mrd = 1; srcb = 2'b01; irw = mr; pw = mr; end
            2: srcb = 2'b11;
            3: begin asa = 1; aop = 2'b10; end
            4: rw = 1;
            5: begin asa = 1; srcb = 2'b10; end
            6: begin mrd = 1; iord = 1; end
            7: begin mwr = 1; iord = 1; end
            8: begin rw = 1; m2r = 1; end
            9: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 1; end
            default: ;
        endcase
        return {pw, pwc, iord, mrd, mwr, irw, m2r, rw, asa, psrc, srcb, aop};
    endfunction

    function automatic bit [6:0] rop();
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic bit rmr();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc(bit rst, bit [6:0] op, bit mr, int st, string tag);
        in_t  i;
        exp_t e;
        i.rst = rst; i.op = op; i.mr = mr;
        e.st  = rst ? 0 : st;
        e.ctl = rst ? 14'd0 : ctl_of(st, mr);
        e.flt = rst ? 2'b00 : m_flt;
        e.tag = tag;
        in_q.push_back(i);
        exp_q.push_back(e);
    endtask

    task automatic do_reset(string tag);
        m_flt = 2'b00;
        cyc(1, rop(), rmr(), 0, {tag, "_rst"});
        cyc(0, rop(), rmr(), 0, {tag, "_rst_rel"});
    endtask

    task automatic fault_hold(int n, string tag);
        for (int k = 0; k < n; k++) cyc(0, rop(), rmr(), 15, {tag, "_fault"});
    endtask

    task automatic mem_phase(int st, int w, string tag, output bit ok);
        ok = 1;
        for (int k = 0; k <= w; k++) begin
            if (k < w) begin
                cyc(0, rop(), 0, st, {tag, "_wait"});
                if (T != 0 && k == T) begin
                    ok = 0;
                    m_flt = 2'b10;
                    return;
                end
            end else begin
                cyc(0, rop(), 1, st, {tag, "_ready"});
            end
        end
    endtask

    task automatic instr(bit [6:0] op, int wf, int wm, int hold, string tag);
        bit ok;
        mem_phase(1, wf, {tag, "_fetch"}, ok);
        if (!ok) begin fault_hold(hold, tag); return; end
        cyc(0, op, rmr(), 2, {tag, "_decode"});
        case (op)
            R_OP: begin
                cyc(0, rop(), rmr(), 3, {tag, "_exec"});
                cyc(0, rop(), rmr(), 4, {tag, "_wbr"});
            end
            LW_OP, SW_OP: begin
                cyc(0, op, rmr(), 5, {tag, "_addr"});
                mem_phase(op == LW_OP ? 6 : 7, wm, {tag, "_mem"}, ok);
                if (!ok) begin fault_hold(hold, tag); return; end
                if (op == LW_OP) cyc(0, rop(), rmr(), 8, {tag, "_wbld"});
            end
            BQ_OP: cyc(0, rop(), rmr(), 9, {tag, "_branch"});
            default: begin
                m_flt = 2'b01;
                fault_hold(hold, tag);
            end
        endcase
    endtask

    function automatic int rwait();
        return ($urandom_range(0, 9) == 0) ? T + 1 : $urandom_range(0, T);
    endfunction

    initial begin
        bit [6:0] op;
        m_flt = 2'b00;
        do_reset("init");
        instr(R_OP, 0, 0, 3, "rtype");
        instr(LW_OP, 0, 3, 3, "lw3");
        instr(SW_OP, 0, 0, 3, "sw");
        instr(BQ_OP, 0, 0, 3, "beq");
        instr(7'b1111111, 0, 0, 100, "illegal");
        do_reset("illegal");
        instr(R_OP, T + 1, 0, 5, "fetch_to");
        do_reset("fetch_to");
        instr(BQ_OP, T, 0, 3, "fetch_limit_ok");
        instr(LW_OP, 1, T + 1, 4, "mem_to");
        do_reset("mem_to");
        cyc(0, rop(), 1, 1, "swrst_fetch");
        cyc(0, SW_OP, rmr(), 2, "swrst_decode");
        cyc(0, SW_OP, rmr(), 5, "swrst_addr");
        cyc(0, rop(), 0, 7, "swrst_memwr");
        cyc(0, rop(), 0, 7, "swrst_memwr2");
        do_reset("swrst");
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    op = R_OP;
                2, 3:    op = LW_OP;
                4, 5:    op = SW_OP;
                6, 7:    op = BQ_OP;
                8:       op = 7'b0010011;
                default: op = rop();
            endcase
            instr(op, rwait(), rwait(), $urandom_range(1, 4), "rand");
            if (m_flt != 2'b00) do_reset("rand");
        end
        n_plan = exp_q.size();
        plan_ready = 1'b1;
    end

    initial begin
        in_t i;
        bus.opcode = 7'd0;
        bus.mem_ready = 1'b0;
        wait (plan_ready);
        @(posedge clk);
        while (in_q.size() > 0) begin
            i = in_q.pop_front();
            #1;
            reset = i.rst;
            bus.opcode = i.op;
            bus.mem_ready = i.mr;
            @(posedge clk);
        end
    end

    initial begin
        exp_t e;
        bit [13:0] act;
        wait (plan_ready);
        @(posedge clk);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            act = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
                   bus.irwrite, bus.memtoreg, bus.regwrite, bus.alusrca, bus.pcsource,
                   bus.alusrcb, bus.aluop};
            checks++;
            if (bus.state !== 4'(e.st) || act !== e.ctl || bus.fault !== e.flt) begin
                errors++;
                $display("FAIL %s: got state=%0d ctl=%b fault=%b, expected state=%0d ctl=%b fault=%b",
                         e.tag, bus.state, act, bus.fault, e.st, e.ctl, e.flt);
            end
        end
        if (checks != n_plan) begin
            errors++;
            $display("FAIL count: %0d checks run, %0d planned", checks, n_plan);
        end
        if (errors != 0)
            $display("FAIL Result: errors=%0d of %0d checks", errors, checks);
        else
            $display("PASS Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
